prng_stream_gen: RTL and testbench
==================================

// Module: prng_stream_gen
// PURPOSE
// - Parametrised pseudo-random word source with valid/ready streaming output.
// - Two modes: wrapping up-counter and Galois LFSR. Seed is loadable at run time.
// - Feeds test-pattern and stimulus consumers in the datapath.
// - Words are registered and held under backpressure. The sequence never stalls in the all-zero LFSR lock-up state.
// PARAMETERS
// - WIDTH  16       output / state width, 2..32
// - SEED   16'h4A46 reset seed; substitute seed for zero loads in LFSR mode; must be nonzero
// - TAPS   16'hB400 Galois feedback mask (default: x^16+x^14+x^13+x^11, maximal length)
// PORTS
// - clk        in   1      single clock, rising edge
// - reset      in   1      asynchronous, active-high reset
// - enable     in   1      1 = generator may produce words
// - mode       in   1      0 = counter, 1 = Galois LFSR; sampled every cycle
// - load       in   1      1-cycle seed load strobe
// - seed_in    in   WIDTH  seed value captured on load
// - out_data   out  WIDTH  generated word
// - out_valid  out  1      out_data holds an unconsumed word
// - out_ready  in   1      consumer accepts out_data when out_valid & out_ready
// - accept_cnt out  32     handshake count; present only with PRNG_STATS_EN
// BEHAVIOUR
// - Reset (async, any time, including mid-handshake): state=SEED, out_data=0, out_valid=0, accept_cnt=0.
// - next(s), counter mode: s+1, wraps from all-ones to 0.
// - next(s), LFSR mode: (s>>1) ^ (s[0] ? TAPS : 0).
// - next(s), LFSR mode with s==0 (entered from counter mode): next = SEED (lock-up recovery).
// - Define slot = !out_valid | out_ready.
// - Priority each cycle: load > produce > drain.
// - load=1: state = (mode==1 && seed_in==0) ? SEED : seed_in.
// - load=1: out_valid=0 (pending word flushed); out_data holds its value.
// - load=1 with a simultaneous handshake: the handshake counts as completed.
// - produce (enable & slot & !load): out_data=state, out_valid=1, state=next(state).
// - drain (out_valid & out_ready & !(enable & !load) case not producing): out_valid=0.
// - No produce: state holds. state advances only when a word is produced.
// - Latency: first out_valid rises 1 clk after enable is first high.
// - Latency: the first word after reset or load equals the seed itself.
// - Throughput: 1 word/clk while enable=1 and out_ready=1.
// - Backpressure: while out_valid=1 and out_ready=0, out_data and state are frozen.
// - enable=0: no new words; a pending valid word stays until taken.
// - A mode change takes effect on the next produce. The word already in out_data is unaffected.
// - In LFSR mode, period is 2^WIDTH-1 for maximal TAPS; 0 is never emitted.
// - In counter mode, period is 2^WIDTH.
// CONFIGURATION
// - PRNG_STATS_EN defined: accept_cnt port exists.
// - accept_cnt +1 on each out_valid & out_ready; saturates at 32'hFFFF_FFFF.
// - accept_cnt is cleared by reset and by load. The load clear wins over a same-cycle increment.
// - PRNG_STATS_EN undefined: accept_cnt port and its logic are absent. All other behaviour is identical.
// TESTING
// - T1 LFSR: reset, mode=1, enable=1, ready=1 -> out_data 0x4A46, 0x2523, 0xA691 on consecutive valid cycles.
// - T2 Counter wrap: load seed_in=0xFFFE, mode=0 -> outputs 0xFFFE, 0xFFFF, 0x0000, 0x0001.
// - T3 Backpressure: ready=0 for 3 clks with valid=1 -> out_data stable.
// - T3 (cont.): raise ready -> next word is the successor of the held word; none skipped or repeated.
// - T4 Zero seed: mode=1, load seed_in=0 -> valid drops; next word 0x4A46.
// - T4 (cont.): mode=0, load seed_in=0 -> next word 0x0000.
// - T5 Lock-up recovery: mode=0 at state 0, switch mode=1 -> words 0x0000, then 0x4A46.
// - T6 Reset mid-stream + stats: 5 accepts -> accept_cnt=5; assert reset with valid=1.
// - T6 (cont.): reset -> out_valid=0 and accept_cnt=0 immediately (async); first word after release is 0x4A46.

Source files
------------

// File: rtl/prng_stream_gen.sv
// Pseudo-random word source (wrapping counter or Galois LFSR) with a registered valid/ready output.
// Optional handshake statistics counter: define PRNG_STATS_EN to add the accept_cnt port.
module prng_stream_gen #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = 16'h4A46,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PRNG_STATS_EN
    ,
    output logic [31:0]      accept_cnt
`endif
);

    typedef enum logic {
        MODE_COUNTER = 1'b0,
        MODE_LFSR    = 1'b1
    } mode_e;

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             slot;
    logic             handshake;

    // An all-zero state in LFSR mode can only arrive from counter mode; restart from SEED.
    function automatic logic [WIDTH-1:0] next_state(input logic [WIDTH-1:0] s, input mode_e m);
        if (m == MODE_COUNTER) begin
            return s + WIDTH'(1);
        end
        if (s == '0) begin
            return SEED;
        end
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    assign slot      = !out_valid_q || out_ready;
    assign handshake = out_valid_q && out_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (load) begin
            state_d     = (mode_e'(mode) == MODE_LFSR && seed_in == '0) ? SEED : seed_in;
            out_valid_d = 1'b0;
        end else if (enable && slot) begin
            out_data_d  = state_q;
            out_valid_d = 1'b1;
            state_d     = next_state(state_q, mode_e'(mode));
        end else if (handshake) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q     <= SEED;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

`ifdef PRNG_STATS_EN
    logic [31:0] accept_cnt_q, accept_cnt_d;

    // A load clears the count even when a handshake completes in the same cycle.
    always_comb begin
        accept_cnt_d = accept_cnt_q;
        if (load) begin
            accept_cnt_d = '0;
        end else if (handshake && accept_cnt_q != 32'hFFFF_FFFF) begin
            accept_cnt_d = accept_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accept_cnt_q <= '0;
        end else begin
            accept_cnt_q <= accept_cnt_d;
        end
    end

    assign accept_cnt = accept_cnt_q;
`endif

endmodule

// File: tb/tb_prng_stream_gen.sv
// Self-checking bench for prng_stream_gen: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model (PRNG_STATS_EN aware).
module tb_prng_stream_gen;

    localparam int          W    = 16;
    localparam logic [15:0] SEED = 16'h4A46;
    localparam logic [15:0] TAPS = 16'hB400;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          mode;
    logic          load;
    logic [W-1:0]  seed_in;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
`ifdef PRNG_STATS_EN
    logic [31:0]   accept_cnt;
`endif

    prng_stream_gen #(.WIDTH(W), .SEED(SEED), .TAPS(TAPS)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .mode      (mode),
        .load      (load),
        .seed_in   (seed_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef PRNG_STATS_EN
        ,
        .accept_cnt(accept_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: generator value, held word, valid flag and handshake count.
    logic [W-1:0] m_state;
    logic [W-1:0] m_data;
    logic         m_valid;
    longint       m_cnt;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_next(input logic [W-1:0] s, input logic lfsr);
        int v;
        v = int'(s);
        if (!lfsr) return W'((v + 1) % (1 << W));
        if (v == 0) return SEED;
        return W'((v / 2) ^ ((v % 2 == 1) ? int'(TAPS) : 0));
    endfunction

    task automatic model_reset();
        m_state = SEED;
        m_data  = '0;
        m_valid = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic model_clock();
        bit took;
        took = m_valid && out_ready;
        if (load) begin
            m_state = (mode && seed_in == '0) ? SEED : seed_in;
            m_valid = 1'b0;
            m_cnt   = 0;
        end else begin
            if (took && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (enable && (!m_valid || out_ready)) begin
                m_data  = m_state;
                m_valid = 1'b1;
                m_state = model_next(m_state, mode);
            end else if (took) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check("valid", {31'b0, out_valid}, {31'b0, m_valid});
        check("data", {16'b0, out_data}, {16'b0, m_data});
`ifdef PRNG_STATS_EN
        check("accept_cnt", accept_cnt, m_cnt[31:0]);
`endif
    endtask

    // One clock: model follows the inputs seen at the edge, outputs are compared 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (!reset) model_clock();
        #1;
        compare_all();
    endtask

    task automatic set_in(input logic en, input logic md, input logic ld,
                          input logic [W-1:0] sd, input logic rdy);
        enable    = en;
        mode      = md;
        load      = ld;
        seed_in   = sd;
        out_ready = rdy;
    endtask

    initial begin
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0);
        reset = 1'b1;
        model_reset();
        #12;
        compare_all();
        check("reset_valid", {31'b0, out_valid}, 32'd0);
        check("reset_data", {16'b0, out_data}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // T1: LFSR sequence from the reset seed.
        set_in(1'b1, 1'b1, 1'b0, '0, 1'b1);
        step(); check("t1_w0", {16'b0, out_data}, 32'h4A46);
        step(); check("t1_w1", {16'b0, out_data}, 32'h2523);
        step(); check("t1_w2", {16'b0, out_data}, 32'hA691);

        // T2: counter wrap from a loaded seed.
        set_in(1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b1);
        step(); check("t2_flush", {31'b0, out_valid}, 32'd0);
        load = 1'b0;
        step(); check("t2_w0", {16'b0, out_data}, 32'hFFFE);
        step(); check("t2_w1", {16'b0, out_data}, 32'hFFFF);
        step(); check("t2_w2", {16'b0, out_data}, 32'h0000);
        step(); check("t2_w3", {16'b0, out_data}, 32'h0001);

        // T3: backpressure holds the word, release gives its successor.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_hold", {16'b0, out_data}, 32'h0001);
            check("t3_valid", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        step(); check("t3_next", {16'b0, out_data}, 32'h0002);

        // T4: zero seed in LFSR mode substitutes SEED; in counter mode it is kept.
        set_in(1'b1, 1'b1, 1'b1, 16'h0000, 1'b1);
        step();
        check("t4_flush", {31'b0, out_valid}, 32'd0);
        check("t4_data_held", {16'b0, out_data}, 32'h0002);
        load = 1'b0;
        step(); check("t4_lfsr_w0", {16'b0, out_data}, 32'h4A46);
        set_in(1'b1, 1'b0, 1'b1, 16'h0000, 1'b1);
        step();
        load = 1'b0;
        step(); check("t4_cnt_w0", {16'b0, out_data}, 32'h0000);

        // T5: lock-up recovery when entering LFSR mode with a zero state.
        set_in(1'b1, 1'b0, 1'b1, 16'h0000, 1'b1);
        step();
        load = 1'b0;
        mode = 1'b1;
        step(); check("t5_w0", {16'b0, out_data}, 32'h0000);
        step(); check("t5_w1", {16'b0, out_data}, 32'h4A46);

        // T6: five accepts, then asynchronous reset mid-stream.
        set_in(1'b1, 1'b1, 1'b1, 16'h1234, 1'b1);
        step();
        load = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("t6_valid_before", {31'b0, out_valid}, 32'd1);
`ifdef PRNG_STATS_EN
        check("t6_cnt5", accept_cnt, 32'd5);
`endif
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        check("t6_async_valid", {31'b0, out_valid}, 32'd0);
`ifdef PRNG_STATS_EN
        check("t6_async_cnt", accept_cnt, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        step(); check("t6_first", {16'b0, out_data}, 32'h4A46);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            enable    = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            load      = ($urandom_range(0, 19) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
                compare_all();
                @(negedge clk);
                reset = 1'b0;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
